// File: rtl/spongent_padder.sv
// spongent_padder: captures one left-aligned message word and applies sponge padding
// (message bits, a single '1', then zeros up to the next multiple of r). It streams
// the padded message MSB-first as r-bit rate blocks and flags the final block.
//
// Handshake: a block transfers on a clock edge where block_valid_o && block_ready_i.
// While block_valid_o is high and block_ready_i is low, block_o and block_last_o hold
// stable. block_valid_o never depends on block_ready_i in the same cycle.
module spongent_padder #(
    parameter int DATA_WIDTH = 64,
    parameter int r          = 8,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] msg,
    input  logic [LEN_W-1:0]      msg_len,
    output logic                  busy,
    output logic [r-1:0]          block_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  block_last_o,
    output logic                  done_o
);

    // The padded message needs one extra block: a full-length message still
    // needs room for the '1' marker.
    localparam int PW     = DATA_WIDTH + r;
    localparam int BLOCKS = DATA_WIDTH / r;
    localparam int CNT_W  = $clog2(BLOCKS + 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         p;
    logic [CNT_W-1:0]      cnt;

    logic [LEN_W-1:0]      len_sat;
    logic [LEN_W-1:0]      len_blocks;
    logic [DATA_WIDTH-1:0] keep_mask;
    logic [PW-1:0]         p_load;
    logic [CNT_W-1:0]      cnt_load;
    logic                  handshake;
    logic                  last_block;

    // Build the padded shift-register image and block count from the request.
    always_comb begin
        len_sat    = (msg_len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : msg_len;
        len_blocks = len_sat / LEN_W'(r);
        // Keep only the top len_sat bits; a shift by DATA_WIDTH keeps everything.
        keep_mask  = ~({DATA_WIDTH{1'b1}} >> len_sat);
        // The marker lands directly after the last message bit.
        p_load     = {msg & keep_mask, {r{1'b0}}} | ({1'b1, {(PW-1){1'b0}}} >> len_sat);
        cnt_load   = CNT_W'(len_blocks) + CNT_W'(1);
    end

    assign busy          = (state != IDLE);
    assign block_valid_o = (state == SEND);
    assign done_o        = (state == DONE);
    assign last_block    = (cnt == CNT_W'(1));
    assign block_last_o  = block_valid_o & last_block;
    assign block_o       = block_valid_o ? p[PW-1 -: r] : '0;
    assign handshake     = block_valid_o & block_ready_i;

    // FSM, shift register and block counter; reset aborts any stream immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p     <= p_load;
                        cnt   <= cnt_load;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        p   <= {p[PW-r-1:0], {r{1'b0}}};
                        cnt <= cnt - CNT_W'(1);
                        if (last_block) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spongent_padder.sv
// tb_spongent_padder: directed vectors with hand-computed padded block sequences.
module tb_spongent_padder;

    localparam int DW = 64;
    localparam int R  = 8;
    localparam int LW = 7;

    // clock / reset
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] msg;
    logic [LW-1:0] msg_len;
    logic          busy;
    logic [R-1:0]  block_o;
    logic          block_valid_o;
    logic          block_ready_i;
    logic          block_last_o;
    logic          done_o;

    always #5 clk = ~clk;

    spongent_padder #(
        .DATA_WIDTH(DW),
        .r(R),
        .LEN_W(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .msg(msg),
        .msg_len(msg_len),
        .busy(busy),
        .block_o(block_o),
        .block_valid_o(block_valid_o),
        .block_ready_i(block_ready_i),
        .block_last_o(block_last_o),
        .done_o(done_o)
    );

    int total = 0;
    int bad   = 0;

    // expected block sequence for the current stream
    logic [R-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and walk the expected blocks.
    // stall_idx/stall_n: hold ready low for stall_n cycles on that block.
    // poke_idx: re-pulse start with different data on that block.
    // abort_idx: assert reset mid-cycle on that block and stop the stream.
    task automatic run_stream(input logic [DW-1:0] m, input logic [LW-1:0] len,
                              input int stall_idx, input int stall_n,
                              input int poke_idx, input int abort_idx);
        int n;
        n       = exp_q.size();
        start   = 1'b1;
        msg     = m;
        msg_len = len;
        step();
        start   = 1'b0;
        msg     = '1;
        msg_len = '0;
        check("first_valid", block_valid_o, 1);
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                block_ready_i = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("stall_blk", block_o, exp_q[i]);
                    check("stall_valid", block_valid_o, 1);
                    check("stall_last", block_last_o, (i == n - 1));
                    step();
                end
                block_ready_i = 1'b1;
            end
            if (i == abort_idx) begin
                check("pre_abort_blk", block_o, exp_q[i]);
                #1;
                rst = 1'b1;
                #1;
                check("abort_valid", block_valid_o, 0);
                check("abort_busy", busy, 0);
                check("abort_blk", block_o, 0);
                check("abort_last", block_last_o, 0);
                step();
                rst = 1'b0;
                step();
                check("abort_idle", busy, 0);
                return;
            end
            check("blk", block_o, exp_q[i]);
            check("valid", block_valid_o, 1);
            check("last", block_last_o, (i == n - 1));
            check("busy", busy, 1);
            check("no_done", done_o, 0);
            if (i == poke_idx) begin
                start   = 1'b1;
                msg     = 64'hDEAD_BEEF_CAFE_F00D;
                msg_len = 7'd64;
            end
            step();
            start = 1'b0;
        end
        check("done", done_o, 1);
        check("done_valid", block_valid_o, 0);
        check("done_busy", busy, 1);
        // start while leaving DONE must be ignored
        start   = 1'b1;
        msg     = 64'h1111_2222_3333_4444;
        msg_len = 7'd16;
        step();
        start   = 1'b0;
        check("done_pulse", done_o, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", block_valid_o, 0);
        step();
        check("still_idle", busy, 0);
    endtask

    task automatic load_full();
        exp_q = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h80};
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        msg           = '0;
        msg_len       = '0;
        block_ready_i = 1'b1;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_valid", block_valid_o, 0);
        check("rst_blk", block_o, 0);
        check("rst_last", block_last_o, 0);
        check("rst_done", done_o, 0);
        rst = 1'b0;
        step();
        check("idle_after_rst", busy, 0);

        // 1: full 64-bit message
        load_full();
        run_stream(64'h0123_4567_89AB_CDEF, 7'd64, -1, 0, -1, -1);

        // 2: empty message, all bits masked
        exp_q = {8'h80};
        run_stream(64'hFFFF_FFFF_FFFF_FFFF, 7'd0, -1, 0, -1, -1);

        // 3: 12-bit message, low bits must not leak
        exp_q = {8'hAB, 8'hC8};
        run_stream(64'hABCF_FFFF_FFFF_FFFF, 7'd12, -1, 0, -1, -1);

        // 4: stall 3 cycles on block 45
        load_full();
        run_stream(64'h0123_4567_89AB_CDEF, 7'd64, 2, 3, -1, -1);

        // 5: start re-pulsed mid-stream, then reset on block 89
        load_full();
        run_stream(64'h0123_4567_89AB_CDEF, 7'd64, -1, 0, 1, 4);
        exp_q = {8'h5A, 8'h80};
        run_stream(64'h5A00_0000_0000_0000, 7'd8, -1, 0, -1, -1);

        // 6: out-of-range length saturates to 64
        load_full();
        run_stream(64'h0123_4567_89AB_CDEF, 7'd70, -1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
